instr_mem_ctrl: RTL
===================

Name: instr_mem_ctrl

Overview:
- Parametrised, loadable instruction memory with a fetch handshake for the CPU front end.
- Succeeds the fixed 16-bit hard-coded program store.
  - The program is streamed in by a loader after reset.
  - Fetches are byte-addressed, with a registered one-cycle read.
- Detects misaligned and out-of-program fetches and halts cleanly instead of returning undefined data.
- Sits between the PC register and the decode stage.

Parameters:
- DATA_W, 16, instruction width in bits; multiple of 8, minimum 16.
- DEPTH, 64, number of instruction words.
- ADDR_W, 16, width of the byte-address PC.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- load_start  in  1  pulse; begins a new program load.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_W  instruction word to append.
- load_done  in  1  pulse; ends the load.
- load_ready  out  1  load word accepted when load_valid && load_ready.
- fetch_req  in  1  fetch request.
- pc  in  ADDR_W  byte address of the fetch.
- fetch_ready  out  1  fetch accepted when fetch_req && fetch_ready.
- instr_valid  out  1  instruction valid; one-cycle pulse.
- instruction  out  DATA_W  fetched word.
- fault  out  1  sticky fault flag.
- fault_code  out  2  fault reason: 0 none, 1 misaligned, 2 out of range.
- prog_len  out  $clog2(DEPTH)+1  number of words loaded.
- halted  out  1  high in the HALT state.

Behaviour:
- Reset values:
  - State IDLE.
  - prog_len=0, load_ready=0, fetch_ready=0, instr_valid=0, instruction=0, fault=0, fault_code=0, halted=0.
  - Array contents are not reset.
- States and transitions:
  - IDLE: load_start -> LOAD.
  - LOAD:
    - load_ready=1; each accepted word is written at index prog_len, then prog_len increments.
    - When prog_len==DEPTH, load_ready=0 and further load_valid is ignored (no wrap).
    - load_done -> RUN if prog_len>0, else IDLE.
  - RUN:
    - fetch_ready=1; load_ready=0.
    - load_start -> LOAD, clearing prog_len, fault and fault_code.
  - HALT:
    - halted=1; fetch_ready=0.
    - load_start -> LOAD, clearing prog_len, fault and fault_code.
- Fetch word index = pc >> log2(DATA_W/8).
  - Misaligned when pc low log2(DATA_W/8) bits != 0.
  - Out of range when index >= prog_len.
- Accepted fetch:
  - Next cycle instr_valid=1 and instruction=array[index].
  - Back-to-back fetches give one result per cycle.
  - instruction holds its value when no fetch is accepted.
- Faulting fetch:
  - Next cycle instr_valid=1, instruction=0 (NOP/halt word), fault=1, fault_code set.
  - State -> HALT.
  - Misaligned takes priority over out of range.
- Simultaneous events:
  - load_start in the same cycle as fetch_req in RUN: load wins, the fetch is not accepted.
  - load_start during LOAD restarts the load (prog_len=0).
  - load_done with load_valid in the same cycle: the word is written first, then the state changes.
- Reset mid-operation:
  - Any in-flight fetch is dropped (instr_valid=0).
  - A partial load is discarded (prog_len=0).
- Arithmetic: prog_len is unsigned and saturates at DEPTH. The index compare is zero-extended to the wider operand.

Optional Feature:
- Macro: INSTR_MEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed at load.
  - On fetch, a parity mismatch gives instruction=0, fault=1, fault_code=3, state -> HALT.
  - Parity is checked after the alignment and range checks.
- When undefined: no parity storage, and fault_code 3 never occurs.

Decomposition:
- Package instr_mem_pkg:
  - State enum (IDLE, LOAD, RUN, HALT).
  - Fault-code constants (FLT_NONE, FLT_MISALIGN, FLT_RANGE, FLT_PARITY).
  - NOP_WORD=0.
- Sub-module instr_mem_array:
  - Single-port synchronous RAM, DEPTH x (DATA_W or DATA_W+1).
  - Registered read, no reset.
  - The controller owns the FSM, checks and output register.

Test Plan:
- Reset then load F120, F121, 93FF, load_done.
  - prog_len=3, state RUN.
  - Fetch pc=0 -> next cycle instr_valid=1, instruction=F120.
- Back-to-back fetches pc=2 then pc=4 -> F121 then 93FF on consecutive cycles.
- Fetch pc=3 -> instruction=0000, fault=1, fault_code=1, halted=1, fetch_ready=0.
- With prog_len=3, fetch pc=6 -> fault_code=2, halted=1.
  - Then load_start -> fault=0, prog_len=0, load_ready=1.
- Load 64 words with DEPTH=64, then a 65th load_valid -> load_ready=0, prog_len stays 64.
- Assert reset after 2 of 3 words are loaded -> prog_len=0, state IDLE, all outputs at reset values.
- With INSTR_MEM_PARITY_EN, force a bit flip in the stored word at index 1, then fetch pc=2 -> fault_code=3, instruction=0000.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared types and constants for the loadable instruction memory.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_RANGE    = 2'd2;
  localparam logic [1:0] FLT_PARITY   = 2'd3;

  // Word returned on a faulting fetch; decode treats it as NOP/halt.
  localparam int unsigned NOP_WORD = 0;

endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: single-port synchronous RAM with registered read, no reset.
module instr_mem_array #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write has the port when both are requested; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: loadable instruction memory with fetch handshake and fault halt.
// Optional build macro INSTR_MEM_PARITY_EN adds a stored even-parity bit per word.
//
// state | meaning
// IDLE  | no program; waiting for load_start
// LOAD  | accepting program words at index prog_len
// RUN   | serving fetches, one result per cycle
// HALT  | faulted; only load_start leaves
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_done,
  output logic                       load_ready,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          pc,
  output logic                       fetch_ready,
  output logic                       instr_valid,
  output logic [DATA_W-1:0]          instruction,
  output logic                       fault,
  output logic [1:0]                 fault_code,
  output logic [$clog2(DEPTH):0]     prog_len,
  output logic                       halted
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int LEN_W = $clog2(DEPTH) + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMP_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
`ifdef INSTR_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  prog_len_q;
  logic              fault_q;
  logic [1:0]        code_q;
  logic              valid_q;
  logic              zero_q;   // output word forced to NOP (reset or last fetch faulted)
  logic              rd_ok_q;  // rdata holds a fresh, check-passed read
  logic              wr_en, re, fetch_acc, par_err;
  logic [ADDR_W-1:0] idx;
  logic              misalign, out_range, full;
  logic [AW-1:0]     ram_addr;
  logic [MEM_W-1:0]  wdata, rdata;

  assign idx       = pc >> OFF_W;
  assign misalign  = |pc[OFF_W-1:0];
  assign out_range = CMP_W'(idx) >= CMP_W'(prog_len_q);
  assign full      = (prog_len_q == LEN_W'(DEPTH));
  assign re        = fetch_acc && !misalign && !out_range;
  assign ram_addr  = (state == LOAD) ? prog_len_q[AW-1:0] : idx[AW-1:0];

`ifdef INSTR_MEM_PARITY_EN
  assign wdata   = {^load_data, load_data};
  assign par_err = rd_ok_q && (^rdata);
`else
  assign wdata   = load_data;
  assign par_err = 1'b0;
`endif

  instr_mem_array #(.WIDTH(MEM_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (wr_en),
    .re    (re),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake decode; load_start always wins over other events.
  always_comb begin
    state_nxt   = state;
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    halted      = 1'b0;
    wr_en       = 1'b0;
    fetch_acc   = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_nxt = LOAD;
      end
      LOAD: begin
        load_ready = !full;
        wr_en      = load_valid && !full && !load_start;
        if (load_start)
          state_nxt = LOAD;
        else if (load_done)
          state_nxt = ((prog_len_q != '0) || wr_en) ? RUN : IDLE;
      end
      RUN: begin
        fetch_ready = !par_err;
        if (load_start)
          state_nxt = LOAD;
        else if (par_err)
          state_nxt = HALT;
        else if (fetch_req) begin
          fetch_acc = 1'b1;
          if (misalign || out_range) state_nxt = HALT;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (load_start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Program length, sticky fault and fetch result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_len_q <= '0;
      fault_q    <= 1'b0;
      code_q     <= FLT_NONE;
      valid_q    <= 1'b0;
      zero_q     <= 1'b1;
      rd_ok_q    <= 1'b0;
    end else begin
      valid_q <= fetch_acc;
      rd_ok_q <= re;
      if (fetch_acc)    zero_q <= !re;
      else if (par_err) zero_q <= 1'b1;
      if (load_start) begin
        prog_len_q <= '0;
        fault_q    <= 1'b0;
        code_q     <= FLT_NONE;
      end else begin
        if (wr_en) prog_len_q <= prog_len_q + LEN_W'(1);
        if (fetch_acc && misalign) begin
          fault_q <= 1'b1;
          code_q  <= FLT_MISALIGN;
        end else if (fetch_acc && out_range) begin
          fault_q <= 1'b1;
          code_q  <= FLT_RANGE;
        end else if (par_err && (state == RUN)) begin
          fault_q <= 1'b1;
          code_q  <= FLT_PARITY;
        end
      end
    end
  end

  // A parity error is only known once the word is read, so it is reported in the result cycle.
  assign instr_valid = valid_q;
  assign instruction = (zero_q || par_err) ? DATA_W'(NOP_WORD) : rdata[DATA_W-1:0];
  assign fault       = fault_q || par_err;
  assign fault_code  = par_err ? FLT_PARITY : code_q;
  assign prog_len    = prog_len_q;

endmodule
